// File: rtl/post_eval_gen_if.sv
// Arithmetic-unit link for post_eval_gen: one operation request with two operands
// out, one result with an ack pulse back.
//   master (evaluator): drives unit_req, unit_op, operand A/B fields; reads unit_ack, result fields
//   slave  (arith unit): the mirror image
interface post_eval_gen_if #(
  parameter int unsigned MANT_W = 34,
  parameter int unsigned EXP_W  = 7
);
  logic              unit_req;
  logic [7:0]        unit_op;
  logic              unit_sign_a;
  logic [MANT_W-1:0] unit_mant_a;
  logic [EXP_W-1:0]  unit_exp_a;
  logic              unit_sign_b;
  logic [MANT_W-1:0] unit_mant_b;
  logic [EXP_W-1:0]  unit_exp_b;
  logic              unit_ack;
  logic              unit_sign_res;
  logic [MANT_W-1:0] unit_mant_res;
  logic [EXP_W-1:0]  unit_exp_res;

  modport master (
    output unit_req, unit_op,
    output unit_sign_a, unit_mant_a, unit_exp_a,
    output unit_sign_b, unit_mant_b, unit_exp_b,
    input  unit_ack, unit_sign_res, unit_mant_res, unit_exp_res
  );

  modport slave (
    input  unit_req, unit_op,
    input  unit_sign_a, unit_mant_a, unit_exp_a,
    input  unit_sign_b, unit_mant_b, unit_exp_b,
    output unit_ack, unit_sign_res, unit_mant_res, unit_exp_res
  );
endinterface

// File: rtl/post_eval_gen.sv
// Postfix evaluator: walks a postfix token array, keeps a value stack and hands each
// operator to a shared external arithmetic unit over a req/ack handshake.
// Ports:
//   clock, reset      clock and synchronous active-low reset
//   start             rising edge starts an evaluation (ignored while busy)
//   postfix_size      number of valid tokens
//   postfix           token array, held stable while busy
//   answer            result token, updated only on done
//   done / error      one-cycle completion / failure pulses
//   busy              evaluation in progress
//   err_code          cause of last error: 1 underflow, 2 overflow, 3 bad opcode,
//                     4 malformed, 5 unit timeout; cleared by the next start edge
//   unit              arithmetic unit link (master side)
// Optional: define POST_EVAL_GEN_TIMEOUT_EN to add a 16-bit WAIT watchdog (code 5).
module post_eval_gen #(
  parameter int unsigned DEPTH  = 10,
  parameter int unsigned MANT_W = 34,
  parameter int unsigned EXP_W  = 7,
  parameter int unsigned TOK_W  = 2 + 1 + MANT_W + EXP_W
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic [$clog2(DEPTH+1)-1:0]        postfix_size,
  input  logic [DEPTH-1:0][TOK_W-1:0]       postfix,
  output logic [TOK_W-1:0]                  answer,
  output logic                              done,
  output logic                              busy,
  output logic                              error,
  output logic [2:0]                        err_code,
  post_eval_gen_if.master                   unit
);
  localparam int unsigned PTR_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FLD_W = 1 + MANT_W + EXP_W;

  typedef enum logic [2:0] {IDLE, READ, POP, WAIT, DONE, ERROR} stateE;

  stateE            state;
  logic [PTR_W-1:0] stk;
  logic [PTR_W-1:0] pof;
  logic [TOK_W-1:0] stack [DEPTH];
  logic [7:0]       opReg;
  logic [2:0]       errPend;
  logic             startQ;
`ifdef POST_EVAL_GEN_TIMEOUT_EN
  logic [15:0]      wdog;
`endif

  logic             startEdge;
  logic [TOK_W-1:0] curTok;
  logic [FLD_W-1:0] topFld;
  logic [FLD_W-1:0] secFld;
  logic             isBin;
  logic             isUn;

  assign startEdge = start & ~startQ;
  // A size beyond the array reads as constant 0, so an oversized list trips overflow.
  assign curTok = (pof < PTR_W'(DEPTH)) ? postfix[pof[IDX_W-1:0]] : '0;
  assign topFld = stack[IDX_W'(stk - PTR_W'(1))][FLD_W-1:0];
  assign secFld = stack[IDX_W'(stk - PTR_W'(2))][FLD_W-1:0];

  // Operator classification of the latched opcode.
  always_comb begin
    isBin = opReg inside {8'h2A, 8'h2B, 8'h2C, 8'h2D, 8'hF2, 8'hF3};
    isUn  = opReg inside {8'hF0, 8'hF1, 8'hF4, 8'hF5, 8'hF6};
  end

  // Evaluation sequencer with registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state            <= IDLE;
      stk              <= '0;
      pof              <= '0;
      opReg            <= '0;
      errPend          <= '0;
      startQ           <= 1'b0;
      answer           <= '0;
      done             <= 1'b0;
      busy             <= 1'b0;
      error            <= 1'b0;
      err_code         <= '0;
      unit.unit_req    <= 1'b0;
      unit.unit_op     <= '0;
      unit.unit_sign_a <= 1'b0;
      unit.unit_mant_a <= '0;
      unit.unit_exp_a  <= '0;
      unit.unit_sign_b <= 1'b0;
      unit.unit_mant_b <= '0;
      unit.unit_exp_b  <= '0;
`ifdef POST_EVAL_GEN_TIMEOUT_EN
      wdog             <= '0;
`endif
    end else begin
      startQ <= start;
      done   <= 1'b0;
      error  <= 1'b0;
      case (state)
        IDLE: begin
          if (startEdge) begin
            pof      <= '0;
            stk      <= '0;
            err_code <= '0;
            busy     <= 1'b1;
            state    <= READ;
          end
        end
        READ: begin
          if (pof == postfix_size) begin
            state <= DONE;
          end else if (curTok[TOK_W-1:TOK_W-2] == 2'b00) begin
            if (stk == PTR_W'(DEPTH)) begin
              errPend <= 3'd2;
              state   <= ERROR;
            end else begin
              stack[IDX_W'(stk)] <= curTok;
              stk <= stk + PTR_W'(1);
              pof <= pof + PTR_W'(1);
            end
          end else begin
            opReg <= curTok[7:0];
            pof   <= pof + PTR_W'(1);
            state <= POP;
          end
        end
        POP: begin
          if (!isBin && !isUn) begin
            errPend <= 3'd3;
            state   <= ERROR;
          end else if ((isBin && stk < PTR_W'(2)) || stk == '0) begin
            errPend <= 3'd1;
            state   <= ERROR;
          end else begin
            unit.unit_req    <= 1'b1;
            unit.unit_op     <= opReg;
            // Subtraction is issued as an add with A negated.
            unit.unit_sign_a <= topFld[FLD_W-1] ^ (opReg == 8'h2B);
            unit.unit_mant_a <= topFld[FLD_W-2:EXP_W];
            unit.unit_exp_a  <= topFld[EXP_W-1:0];
            if (isBin) begin
              unit.unit_sign_b <= secFld[FLD_W-1];
              unit.unit_mant_b <= secFld[FLD_W-2:EXP_W];
              unit.unit_exp_b  <= secFld[EXP_W-1:0];
              stk <= stk - PTR_W'(2);
            end else begin
              unit.unit_sign_b <= 1'b0;
              unit.unit_mant_b <= '0;
              unit.unit_exp_b  <= '0;
              stk <= stk - PTR_W'(1);
            end
`ifdef POST_EVAL_GEN_TIMEOUT_EN
            wdog <= '0;
`endif
            state <= WAIT;
          end
        end
        WAIT: begin
          // A pop always precedes this push, so it cannot overflow.
          if (unit.unit_ack) begin
            stack[IDX_W'(stk)] <= {2'b00, unit.unit_sign_res, unit.unit_mant_res, unit.unit_exp_res};
            stk           <= stk + PTR_W'(1);
            unit.unit_req <= 1'b0;
            state         <= READ;
          end
`ifdef POST_EVAL_GEN_TIMEOUT_EN
          else if (wdog == 16'hFFFE) begin
            unit.unit_req <= 1'b0;
            errPend       <= 3'd5;
            state         <= ERROR;
          end else begin
            wdog <= wdog + 16'd1;
          end
`endif
        end
        DONE: begin
          if (stk == PTR_W'(1)) begin
            answer <= stack[0];
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            errPend <= 3'd4;
            state   <= ERROR;
          end
        end
        ERROR: begin
          error    <= 1'b1;
          err_code <= errPend;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_post_eval_gen.sv
// Randomized bench for post_eval_gen with a queue-based postfix reference model and a
// behavioural arithmetic unit with programmable ack latency.
module tb_post_eval_gen;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned MANT_W = 34;
  localparam int unsigned EXP_W  = 7;
  localparam int unsigned TOK_W  = 2 + 1 + MANT_W + EXP_W;
  localparam int unsigned FLD_W  = 1 + MANT_W + EXP_W;
  localparam int unsigned PTR_W  = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [7:0]       op;
    logic [FLD_W-1:0] a;
    logic [FLD_W-1:0] b;
  } txT;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [PTR_W-1:0] postfix_size = '0;
  logic [DEPTH-1:0][TOK_W-1:0] postfix = '0;
  logic [TOK_W-1:0] answer;
  logic done, busy, error;
  logic [2:0] err_code;

  post_eval_gen_if #(.MANT_W(MANT_W), .EXP_W(EXP_W)) unitIf ();

  post_eval_gen #(.DEPTH(DEPTH), .MANT_W(MANT_W), .EXP_W(EXP_W)) dut (
    .clock(clock), .reset(reset), .start(start),
    .postfix_size(postfix_size), .postfix(postfix),
    .answer(answer), .done(done), .busy(busy), .error(error), .err_code(err_code),
    .unit(unitIf)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [TOK_W-1:0] toks [DEPTH+2];
  txT expTx[$];
  logic [TOK_W-1:0] lastAns = '0;
  logic [2:0] lastErr = '0;
  logic [7:0] ops [11] = '{8'h2A, 8'h2B, 8'h2C, 8'h2D, 8'hF2, 8'hF3,
                           8'hF0, 8'hF1, 8'hF4, 8'hF5, 8'hF6};

  function automatic logic [TOK_W-1:0] mkC(input logic [MANT_W-1:0] m);
    return {2'b00, 1'b0, m, EXP_W'(0)};
  endfunction

  function automatic logic [TOK_W-1:0] mkOp(input logic [7:0] op, input logic [1:0] tag);
    logic [TOK_W-1:0] t;
    t = '0;
    t[TOK_W-1:TOK_W-2] = tag;
    t[7:0] = op;
    return t;
  endfunction

  // Arbitrary but deterministic arithmetic unit behaviour.
  function automatic logic [FLD_W-1:0] unitFn(input logic [7:0] op, input logic [FLD_W-1:0] a,
                                              input logic [FLD_W-1:0] b);
    logic [MANT_W-1:0] ma, mb, mr;
    logic [EXP_W-1:0] ea, eb;
    ma = a[FLD_W-2:EXP_W];
    mb = b[FLD_W-2:EXP_W];
    ea = a[EXP_W-1:0];
    eb = b[EXP_W-1:0];
    case (op)
      8'h2A:   mr = ma + mb;
      8'h2C:   mr = MANT_W'(ma * mb);
      default: mr = ma ^ (mb << 1) ^ MANT_W'(op);
    endcase
    return {a[FLD_W-1] ^ b[FLD_W-1], mr, EXP_W'(ea + eb)};
  endfunction

  // Arithmetic unit model: ack on the uLat-th cycle of a request.
  int uLat = 3;
  bit uMute = 1'b0;
  bit forceAck = 1'b0;
  int uCnt = 0;
  always @(negedge clock) begin
    if (unitIf.unit_req && !uMute) begin
      uCnt = uCnt + 1;
      if (uCnt == uLat) begin
        unitIf.unit_ack = 1'b1;
        {unitIf.unit_sign_res, unitIf.unit_mant_res, unitIf.unit_exp_res} =
          unitFn(unitIf.unit_op, {unitIf.unit_sign_a, unitIf.unit_mant_a, unitIf.unit_exp_a},
                 {unitIf.unit_sign_b, unitIf.unit_mant_b, unitIf.unit_exp_b});
      end else begin
        unitIf.unit_ack = 1'b0;
      end
    end else begin
      uCnt = 0;
      unitIf.unit_ack = forceAck;
      if (forceAck) {unitIf.unit_sign_res, unitIf.unit_mant_res, unitIf.unit_exp_res} = '1;
    end
  end

  // Reference: evaluate the token list on a queue stack; code 0 means success.
  task automatic refModel(input int size, output int code, output logic [TOK_W-1:0] ans);
    logic [TOK_W-1:0] st[$];
    logic [TOK_W-1:0] t, t2;
    logic [FLD_W-1:0] a, b;
    logic [7:0] op;
    bit bin, un;
    expTx.delete();
    code = 0;
    ans = lastAns;
    for (int p = 0; p < size; p++) begin
      t = (p < int'(DEPTH)) ? toks[p] : '0;
      if (t[TOK_W-1:TOK_W-2] == 2'b00) begin
        if (st.size() == int'(DEPTH)) begin code = 2; return; end
        st.push_back(t);
      end else begin
        op = t[7:0];
        bin = op inside {8'h2A, 8'h2B, 8'h2C, 8'h2D, 8'hF2, 8'hF3};
        un  = op inside {8'hF0, 8'hF1, 8'hF4, 8'hF5, 8'hF6};
        if (!bin && !un) begin code = 3; return; end
        if (st.size() < (bin ? 2 : 1)) begin code = 1; return; end
        t2 = st.pop_back();
        a = t2[FLD_W-1:0];
        if (op == 8'h2B) a[FLD_W-1] = ~a[FLD_W-1];
        b = '0;
        if (bin) begin
          t2 = st.pop_back();
          b = t2[FLD_W-1:0];
        end
        expTx.push_back('{op, a, b});
        st.push_back({2'b00, unitFn(op, a, b)});
      end
    end
    if (st.size() == 1) ans = st[0];
    else code = 4;
  endtask

  task automatic runExpr(input string name, input int size, input int lat);
    int code;
    logic [TOK_W-1:0] ans;
    int nTx, nDone, nErr, reqLen, drift, cyc, tail;
    bit prevReq;
    txT cur, first;
    nTx = 0; nDone = 0; nErr = 0; reqLen = 0; drift = 0; cyc = 0; tail = -1; prevReq = 1'b0;
    first = '0;
    uLat = lat;
    for (int i = 0; i < int'(DEPTH); i++) postfix[i] = toks[i];
    postfix_size = PTR_W'(size);
    refModel(size, code, ans);
    @(negedge clock);
    checkVal({name, ".errHeld"}, 64'(err_code), 64'(lastErr));
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checkVal({name, ".busyUp"}, 64'(busy), 64'd1);
    checkVal({name, ".errClr"}, 64'(err_code), 64'd0);
    while (tail != 0) begin
      @(negedge clock);
      cyc++;
      if (unitIf.unit_req) begin
        cur.op = unitIf.unit_op;
        cur.a  = {unitIf.unit_sign_a, unitIf.unit_mant_a, unitIf.unit_exp_a};
        cur.b  = {unitIf.unit_sign_b, unitIf.unit_mant_b, unitIf.unit_exp_b};
        if (!prevReq) begin
          if (nTx < expTx.size()) begin
            checkVal({name, ".op"}, 64'(cur.op), 64'(expTx[nTx].op));
            checkVal({name, ".opA"}, 64'(cur.a), 64'(expTx[nTx].a));
            checkVal({name, ".opB"}, 64'(cur.b), 64'(expTx[nTx].b));
          end
          nTx++;
          reqLen = 1;
          first = cur;
        end else begin
          reqLen++;
          if (cur != first) drift++;
        end
      end else if (prevReq) begin
        checkVal({name, ".reqLen"}, 64'(reqLen), 64'(lat));
        checkVal({name, ".reqStable"}, 64'(drift), 64'd0);
        drift = 0;
      end
      prevReq = unitIf.unit_req;
      if (done) nDone++;
      if (error) nErr++;
      if (tail > 0) tail--;
      else if (done || error) tail = 3;
      if (tail < 0 && cyc > 400) begin
        checkVal({name, ".finished"}, 64'(done | error), 64'd1);
        tail = 0;
      end
    end
    checkVal({name, ".nTx"}, 64'(nTx), 64'(expTx.size()));
    checkVal({name, ".nDone"}, 64'(nDone), 64'(code == 0));
    checkVal({name, ".nErr"}, 64'(nErr), 64'(code != 0));
    checkVal({name, ".errCode"}, 64'(err_code), 64'(code));
    checkVal({name, ".answer"}, 64'(answer), 64'(ans));
    checkVal({name, ".busyLow"}, 64'(busy), 64'd0);
    lastAns = ans;
    lastErr = 3'(code);
  endtask

  initial begin
    int sz, r, cnt, seen;
    for (int i = 0; i < int'(DEPTH) + 2; i++) toks[i] = '0;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checkVal("rst.answer", 64'(answer), 64'd0);
    checkVal("rst.flags", 64'({done, busy, error}), 64'd0);
    checkVal("rst.errCode", 64'(err_code), 64'd0);
    checkVal("rst.req", 64'(unitIf.unit_req), 64'd0);
    reset = 1'b1;
    @(negedge clock);

    toks[0] = mkC(2); toks[1] = mkC(3); toks[2] = mkOp(8'h2C, 2'b01);
    runExpr("mul", 3, 3);
    checkVal("mul.result", 64'(answer), 64'(mkC(6)));

    toks[0] = mkC(5); toks[1] = mkC(7); toks[2] = mkOp(8'h2B, 2'b01);
    runExpr("sub", 3, 2);

    toks[0] = mkC(1); toks[1] = mkOp(8'h2A, 2'b01);
    runExpr("under", 2, 1);
    toks[0] = mkC(4); toks[1] = mkOp(8'hF0, 2'b01);
    runExpr("recover", 2, 1);

    for (int i = 0; i < int'(DEPTH); i++) toks[i] = mkC(34'(i + 1));
    runExpr("over", int'(DEPTH) + 1, 1);
    toks[0] = mkC(1); toks[1] = mkC(2);
    runExpr("malformed", 2, 1);
    runExpr("empty", 0, 1);
    toks[0] = mkOp(8'h55, 2'b01);
    runExpr("badop", 1, 1);

    for (int n = 0; n < 120; n++) begin
      sz = ($urandom_range(0, 9) == 0) ? int'(DEPTH) + 1 : int'($urandom_range(0, DEPTH));
      for (int i = 0; i < int'(DEPTH); i++) begin
        r = int'($urandom_range(0, 99));
        if (r < 50) toks[i] = {2'b00, 1'($urandom), MANT_W'({$urandom, $urandom}), EXP_W'($urandom)};
        else if (r < 90) toks[i] = mkOp(ops[$urandom_range(0, 10)], 2'($urandom_range(1, 3)));
        else toks[i] = mkOp(8'($urandom), 2'($urandom_range(1, 3)));
      end
      runExpr("rnd", sz, int'($urandom_range(1, 4)));
    end

    // Reset while waiting on the unit, then a stray ack.
    uMute = 1'b1;
    toks[0] = mkC(1); toks[1] = mkC(2); toks[2] = mkOp(8'h2A, 2'b01);
    for (int i = 0; i < int'(DEPTH); i++) postfix[i] = toks[i];
    postfix_size = PTR_W'(3);
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    cnt = 0;
    while (!unitIf.unit_req && cnt < 20) begin @(negedge clock); cnt++; end
    checkVal("rstWait.reqUp", 64'(unitIf.unit_req), 64'd1);
    reset = 1'b0;
    @(negedge clock);
    checkVal("rstWait.req", 64'(unitIf.unit_req), 64'd0);
    checkVal("rstWait.busy", 64'(busy), 64'd0);
    reset = 1'b1;
    forceAck = 1'b1;
    seen = 0;
    repeat (2) begin @(negedge clock); seen += int'(done | error | unitIf.unit_req | busy); end
    forceAck = 1'b0;
    repeat (3) begin @(negedge clock); seen += int'(done | error | unitIf.unit_req | busy); end
    checkVal("lateAck.activity", 64'(seen), 64'd0);
    checkVal("lateAck.answer", 64'(answer), 64'd0);
    checkVal("lateAck.errCode", 64'(err_code), 64'd0);

    // Silent unit: watchdog or indefinite wait.
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    cnt = 0;
    while (!unitIf.unit_req && cnt < 20) begin @(negedge clock); cnt++; end
    checkVal("silent.reqUp", 64'(unitIf.unit_req), 64'd1);
`ifdef POST_EVAL_GEN_TIMEOUT_EN
    cnt = 1;
    while (unitIf.unit_req && cnt < 70000) begin
      @(negedge clock);
      if (unitIf.unit_req) cnt++;
    end
    checkVal("tmo.reqLen", 64'(cnt), 64'd65535);
    seen = 0;
    repeat (4) begin @(negedge clock); seen += int'(error); end
    checkVal("tmo.error", 64'(seen), 64'd1);
    checkVal("tmo.errCode", 64'(err_code), 64'd5);
`else
    repeat (70000) @(negedge clock);
    checkVal("noTmo.busy", 64'(busy), 64'd1);
    checkVal("noTmo.req", 64'(unitIf.unit_req), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
